addsub_pipe: RTL

- Parametrised, pipelined sum/difference unit.
- Each accepted operand pair (a, b) yields a+b and a-b plus status flags.
- Results appear after a fixed register latency.
- Valid/ready handshakes on both sides, with backpressure stalling the whole pipe.
- Used as the registered arithmetic stage between operand sources and result consumers in the datapath exercises.

---
 rtl/addsub_pipe.sv | 123 ++++++++++++
 1 files changed

// File: rtl/addsub_pipe.sv
// addsub_pipe: pipelined sum/difference unit with valid/ready handshakes.
// Stage 1 computes a+b and a-b at WIDTH+1 bits, including overflow flags and
// optional clamping. The remaining stages only delay the result. The whole
// pipe advances together whenever the output register is empty or is being
// consumed. Bubbles occupy a stage slot just like data.
module addsub_pipe #(
  parameter int WIDTH       = 8,
  parameter int LATENCY     = 2,
  parameter int SIGNED_MODE = 0,
  parameter int SATURATE    = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic [WIDTH-1:0] diff,
  output logic             sum_ovf,
  output logic             diff_ovf,
  output logic             busy
);

  // Each stage carries {sum_ovf, diff_ovf, sum, diff}.
  localparam int DW = 2 * WIDTH + 2;

  logic             advance;
  logic [WIDTH:0]   sum_ext;
  logic [WIDTH:0]   diff_ext;
  logic [WIDTH-1:0] sum_wrap;
  logic [WIDTH-1:0] diff_wrap;
  logic [WIDTH-1:0] pos_max;
  logic [WIDTH-1:0] neg_min;
  logic [WIDTH-1:0] sat_signed;
  logic [WIDTH-1:0] sum_next;
  logic [WIDTH-1:0] diff_next;
  logic             sum_ovf_next;
  logic             diff_ovf_next;
  logic             a_sign;
  logic             b_sign;
  logic [DW-1:0]    calc_next;

  logic [LATENCY-1:0] stage_valid;
  logic [DW-1:0]      stage_data [LATENCY];

  // The pipe moves whenever the output slot is free or is leaving this cycle.
  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

  // Stage-1 arithmetic: widened add/subtract, overflow detection, clamping.
  always_comb begin
    sum_ext    = {1'b0, a} + {1'b0, b};
    diff_ext   = {1'b0, a} - {1'b0, b};
    sum_wrap   = sum_ext[WIDTH-1:0];
    diff_wrap  = diff_ext[WIDTH-1:0];
    a_sign     = a[WIDTH-1];
    b_sign     = b[WIDTH-1];
    pos_max    = {1'b0, {(WIDTH-1){1'b1}}};
    neg_min    = {1'b1, {(WIDTH-1){1'b0}}};
    // A signed overflow always lands on the side given by the sign of a.
    sat_signed = a_sign ? neg_min : pos_max;

    if (SIGNED_MODE != 0) begin
      sum_ovf_next  = (a_sign == b_sign) && (sum_wrap[WIDTH-1] != a_sign);
      diff_ovf_next = (a_sign != b_sign) && (diff_wrap[WIDTH-1] != a_sign);
    end else begin
      // Carry out of the add, borrow out of the subtract.
      sum_ovf_next  = sum_ext[WIDTH];
      diff_ovf_next = diff_ext[WIDTH];
    end

    sum_next  = sum_wrap;
    diff_next = diff_wrap;
    if (SATURATE != 0) begin
      if (sum_ovf_next) begin
        sum_next = (SIGNED_MODE != 0) ? sat_signed : '1;
      end
      if (diff_ovf_next) begin
        diff_next = (SIGNED_MODE != 0) ? sat_signed : '0;
      end
    end

    calc_next = {sum_ovf_next, diff_ovf_next, sum_next, diff_next};
  end

  // Register chain: stage 0 loads the fresh result, later stages copy their predecessor.
  for (genvar gi = 0; gi < LATENCY; gi++) begin : g_stage
    logic          valid_reg;
    logic [DW-1:0] data_reg;
    logic          valid_next;
    logic [DW-1:0] data_next;

    if (gi == 0) begin : g_first
      assign valid_next = in_valid;
      assign data_next  = calc_next;
    end else begin : g_rest
      assign valid_next = stage_valid[gi-1];
      assign data_next  = stage_data[gi-1];
    end

    // Shift on advance, hold everything (bubbles included) on a stall.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        valid_reg <= 1'b0;
        data_reg  <= '0;
      end else if (advance) begin
        valid_reg <= valid_next;
        data_reg  <= data_next;
      end
    end

    assign stage_valid[gi] = valid_reg;
    assign stage_data[gi]  = data_reg;
  end

  assign out_valid = stage_valid[LATENCY-1];
  assign {sum_ovf, diff_ovf, sum, diff} = stage_data[LATENCY-1];
  assign busy = |stage_valid;

endmodule
